pipeline_hazard_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage integer pipeline. Drives write enables and

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/hazard_load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_controller.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard FSM states, register index, NOP encoding.
// Imported by the hazard controller and its load-use detector.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN,
    MULDIV,
    MEM_WAIT
  } hz_state_t;

  typedef logic [4:0] reg_idx_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Load-use compare between the load in EX and the sources read in ID.
// x0 never creates a dependency.
module hazard_load_use_detect
  import pipeline_pkg::*;
(
  input  logic     ex_is_load,
  input  logic     ex_reg_write,
  input  reg_idx_t ex_rd,
  input  reg_idx_t id_rs1,
  input  reg_idx_t id_rs2,
  input  logic     id_use_rs1,
  input  logic     id_use_rs2,
  output logic     hit
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);

  assign hit = ex_is_load & ex_reg_write
             & (ex_rd != '0)
             & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch
// redirect, MUL/DIV occupancy of EX and data-memory wait states.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  reg_idx_t         id_rs1,
  input  reg_idx_t         id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  reg_idx_t         ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic             ex_muldiv,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             if_id_flush,
  output logic             id_ex_wr_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_wr_en,
  output logic             ex_mem_bubble,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_W = $clog2(MULDIV_LATENCY + 1);
  localparam logic [MD_W-1:0] MD_LOAD =
    MD_W'(MULDIV_LATENCY - 1);

  hz_state_t       state, state_nx;
  logic [MD_W-1:0] mdcnt, mdcnt_nx;
  logic            lu_hit;
  logic            mem_stall;
  logic            md_busy;

  hazard_load_use_detect u_lu (
    .ex_is_load   (ex_is_load),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .hit          (lu_hit)
  );

  assign mem_stall = mem_req & ~mem_ready;
  // MUL/DIV keeps counting down while memory freezes the pipe
  assign md_busy = (state != RUN) & (mdcnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      mdcnt        <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      mdcnt <= mdcnt_nx;
      if (!pc_wr_en && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    mdcnt_nx = (mdcnt != '0) ? mdcnt - 1'b1 : '0;
    if (mem_stall) begin
      state_nx = MEM_WAIT;
    end else if (state == RUN && ex_muldiv) begin
      state_nx = MULDIV;
      mdcnt_nx = MD_LOAD;
    end else if (md_busy) begin
      state_nx = MULDIV;
    end else begin
      state_nx = RUN;
    end
  end

  always_comb begin
    pc_wr_en      = 1'b0;
    if_id_wr_en   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_wr_en   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_wr_en  = 1'b0;
    ex_mem_bubble = 1'b0;
    muldiv_busy   = reset_n & (state == MULDIV);
    if (!reset_n || mem_stall) begin
      pc_wr_en = 1'b0;
    end else if (md_busy) begin
      ex_mem_wr_en  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      pc_wr_en     = 1'b1;
      if_id_wr_en  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_wr_en  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_wr_en = 1'b1;
    end else if (lu_hit) begin
      id_ex_wr_en  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_wr_en = 1'b1;
    end else begin
      pc_wr_en     = 1'b1;
      if_id_wr_en  = 1'b1;
      id_ex_wr_en  = 1'b1;
      ex_mem_wr_en = 1'b1;
    end
  end

  // The decoder never issues a MUL/DIV that is also a taken branch
  a_no_md_branch : assert property (
    @(posedge clk) disable iff (!reset_n)
    !(ex_muldiv && ex_branch_taken)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; outputs are checked
// mid-cycle after inputs settle, counters after the following edge.
module tb_pipeline_hazard_controller;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  reg_idx_t    id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_reg_write, ex_is_load;
  logic        ex_muldiv, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_wr_en, if_id_wr_en, if_id_flush;
  logic        id_ex_wr_en, id_ex_bubble;
  logic        ex_mem_wr_en, ex_mem_bubble;
  logic        muldiv_busy;
  logic [31:0] stall_cycles;
  logic        s_pc, s_ifw, s_iff, s_idw, s_idb;
  logic        s_exw, s_exb, s_busy;
  logic [1:0]  sat_cnt;
  logic [7:0]  outs;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] NORM   = 8'b1101_0100;
  localparam logic [7:0] NORM_B = 8'b1101_0101;
  localparam logic [7:0] LU     = 8'b0001_1100;
  localparam logic [7:0] BR     = 8'b1111_1100;
  localparam logic [7:0] FRZ    = 8'b0000_0000;
  localparam logic [7:0] FRZ_B  = 8'b0000_0001;
  localparam logic [7:0] MD     = 8'b0000_0111;
  localparam logic [7:0] MD_NB  = 8'b0000_0110;

  always #5 clk = ~clk;

  assign outs = {pc_wr_en, if_id_wr_en, if_id_flush,
                 id_ex_wr_en, id_ex_bubble,
                 ex_mem_wr_en, ex_mem_bubble, muldiv_busy};

  pipeline_hazard_controller #(
    .MULDIV_LATENCY (4),
    .CNT_W          (32)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_is_load      (ex_is_load),
    .ex_muldiv       (ex_muldiv),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_wr_en        (pc_wr_en),
    .if_id_wr_en     (if_id_wr_en),
    .if_id_flush     (if_id_flush),
    .id_ex_wr_en     (id_ex_wr_en),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_wr_en    (ex_mem_wr_en),
    .ex_mem_bubble   (ex_mem_bubble),
    .muldiv_busy     (muldiv_busy),
    .stall_cycles    (stall_cycles)
  );

  // Narrow counter copy to reach saturation quickly
  pipeline_hazard_controller #(
    .MULDIV_LATENCY (4),
    .CNT_W          (2)
  ) u_sat (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_is_load      (ex_is_load),
    .ex_muldiv       (ex_muldiv),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_wr_en        (s_pc),
    .if_id_wr_en     (s_ifw),
    .if_id_flush     (s_iff),
    .id_ex_wr_en     (s_idw),
    .id_ex_bubble    (s_idb),
    .ex_mem_wr_en    (s_exw),
    .ex_mem_bubble   (s_exb),
    .muldiv_busy     (s_busy),
    .stall_cycles    (sat_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic co(input string tag, input logic [7:0] exp);
    chk(tag, {24'h0, outs}, {24'h0, exp});
  endtask

  task automatic cs(input string tag, input logic [31:0] exp);
    chk(tag, stall_cycles, exp);
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    ex_reg_write = 0; ex_is_load = 0;
    ex_muldiv = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    clr();
    #1;
    co("rst_outs", FRZ);
    cs("rst_cnt", 0);

    @(negedge clk); reset_n = 1'b1; #1;
    co("idle", NORM);

    // load-use on rs1
    @(negedge clk);
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd5;
    id_use_rs1 = 1; id_rs1 = 5'd5; #1;
    co("lu_rs1", LU);
    @(negedge clk); clr(); #1;
    co("lu_after", NORM);
    cs("lu_cnt", 1);

    // load-use on rs2
    @(negedge clk);
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd7;
    id_use_rs2 = 1; id_rs2 = 5'd7; #1;
    co("lu_rs2", LU);

    // matching index but source unused
    @(negedge clk); clr();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd9;
    id_rs1 = 5'd9; #1;
    co("lu_unused", NORM);
    cs("lu2_cnt", 2);

    // load into x0
    @(negedge clk); clr();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd0;
    id_use_rs1 = 1; id_rs1 = 5'd0; #1;
    co("lu_x0", NORM);

    // branch overrides load-use
    @(negedge clk);
    ex_rd = 5'd3; id_rs1 = 5'd3;
    ex_branch_taken = 1; #1;
    co("br_lu", BR);
    cs("x0_cnt", 2);
    chk("sat_2", {30'h0, sat_cnt}, 2);

    // MUL/DIV occupancy
    @(negedge clk); clr(); ex_muldiv = 1; #1;
    co("md_issue", NORM);
    cs("br_cnt", 2);
    @(negedge clk); ex_muldiv = 0; #1;
    co("md_c3", MD);
    @(negedge clk); #1;
    co("md_c2", MD);
    @(negedge clk); #1;
    co("md_c1", MD);
    @(negedge clk); #1;
    co("md_adv", NORM_B);
    cs("md_cnt", 5);
    chk("sat_3", {30'h0, sat_cnt}, 3);
    @(negedge clk); #1;
    co("md_run", NORM);

    // memory stall covering the whole MUL/DIV
    @(negedge clk); ex_muldiv = 1; #1;
    co("md2_issue", NORM);
    @(negedge clk); ex_muldiv = 0; mem_req = 1; #1;
    co("ms_first", FRZ_B);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      co("ms_hold", FRZ);
    end
    @(negedge clk); mem_ready = 1; #1;
    co("ms_ready", NORM);
    cs("ms_cnt", 10);
    @(negedge clk); clr(); #1;
    co("ms_run", NORM);

    // freeze beats branch, branch taken once memory is ready
    @(negedge clk); mem_req = 1; ex_branch_taken = 1; #1;
    co("ms_br", FRZ);
    @(negedge clk); mem_ready = 1; #1;
    co("ms_br_rdy", BR);
    @(negedge clk); clr(); #1;
    co("ms_br_run", NORM);
    cs("ms_br_cnt", 11);

    // memory ready while MUL/DIV still has cycles left
    @(negedge clk); ex_muldiv = 1; #1;
    co("md3_issue", NORM);
    @(negedge clk); ex_muldiv = 0; mem_req = 1; #1;
    co("md3_frz", FRZ_B);
    @(negedge clk); mem_ready = 1; #1;
    co("md3_rdy", MD_NB);
    @(negedge clk); clr(); #1;
    co("md3_c1", MD);
    @(negedge clk); #1;
    co("md3_adv", NORM_B);
    @(negedge clk); #1;
    co("md3_run", NORM);
    cs("md3_cnt", 14);

    // async reset in the middle of MUL/DIV
    @(negedge clk); ex_muldiv = 1; #1;
    co("md4_issue", NORM);
    @(negedge clk); ex_muldiv = 0; #1;
    co("md4_c3", MD);
    #2 reset_n = 1'b0;
    #1;
    co("arst_outs", FRZ);
    cs("arst_cnt", 0);
    chk("arst_sat", {30'h0, sat_cnt}, 0);
    @(negedge clk); reset_n = 1'b1; #1;
    co("arst_run", NORM);
    @(negedge clk); #1;
    co("arst_run2", NORM);
    cs("arst_cnt2", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
